// File: rtl/sched_egress_mux.sv
// Egress mux: forwards one packet per scheduler grant, one grant queued behind.
// Optional byte-length check is compiled in with SCHED_EGRESS_MUX_LEN_CHECK_EN.
module sched_egress_mux #(
  parameter int NUM_FIFO      = 9,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int SEL_WIDTH     = $clog2(NUM_FIFO),
  parameter int PKT_LEN_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SEL_WIDTH-1:0]              sel_in,
  input  logic                              en_in,
  input  logic [NUM_FIFO*PKT_LEN_WIDTH-1:0] fifo_packet_length,
  input  logic [NUM_FIFO*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_FIFO*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [NUM_FIFO-1:0]               s_axis_tvalid,
  input  logic [NUM_FIFO-1:0]               s_axis_tlast,
  output logic [NUM_FIFO-1:0]               s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [NUM_FIFO-1:0]               pe_tlast,
  output logic                              busy,
  output logic                              grant_drop,
  output logic                              len_err
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [SEL_WIDTH:0] NUM_Q = (SEL_WIDTH+1)'(NUM_FIFO);

  state_t                r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_cur_sel, w_cur_nxt;
  logic [SEL_WIDTH-1:0]  r_pend_sel, w_pend_sel_nxt;
  logic                  r_pend_valid, w_pend_valid_nxt;
  logic                  w_load, w_drop;
  logic                  w_grant_ok, w_out_free, w_take, w_last;
  logic [NUM_FIFO-1:0]   w_onehot;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic [KEEP_WIDTH-1:0] w_tkeep;

  logic                  r_m_tvalid, r_m_tlast;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_WIDTH-1:0] r_m_tkeep;
  logic [NUM_FIFO-1:0]   r_pe;
  logic                  r_drop;

  assign w_grant_ok = en_in && ({1'b0, sel_in} < NUM_Q);
  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_onehot   = {{(NUM_FIFO-1){1'b0}}, 1'b1} << r_cur_sel;
  assign w_tdata    = s_axis_tdata[int'(r_cur_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_tkeep    = s_axis_tkeep[int'(r_cur_sel)*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_take     = (r_state == XFER) && s_axis_tvalid[r_cur_sel]
                      && w_out_free;
  assign w_last     = w_take && s_axis_tlast[r_cur_sel];

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_nxt        = r_cur_sel;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_sel_nxt   = r_pend_sel;
    w_load           = 1'b0;
    w_drop           = en_in && !w_grant_ok;
    unique case (r_state)
      IDLE: begin
        if (w_grant_ok) begin
          w_state_nxt = XFER;
          w_cur_nxt   = sel_in;
          w_load      = 1'b1;
        end
      end
      XFER: begin
        if (w_last) begin
          // Pending grant is promoted; a same-cycle grant refills its slot
          if (r_pend_valid) begin
            w_cur_nxt        = r_pend_sel;
            w_load           = 1'b1;
            w_pend_valid_nxt = w_grant_ok;
            if (w_grant_ok) w_pend_sel_nxt = sel_in;
          end else if (w_grant_ok) begin
            w_cur_nxt = sel_in;
            w_load    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_grant_ok) begin
          if (!r_pend_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_sel_nxt   = sel_in;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cur_sel    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_sel   <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tkeep    <= '0;
      r_pe         <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_sel    <= w_cur_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_sel   <= w_pend_sel_nxt;
      if (w_take) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_tdata;
        r_m_tkeep  <= w_tkeep;
        r_m_tlast  <= s_axis_tlast[r_cur_sel];
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      r_pe   <= w_last ? w_onehot : '0;
      r_drop <= w_drop;
    end
  end

`ifdef SCHED_EGRESS_MUX_LEN_CHECK_EN
  logic [PKT_LEN_WIDTH-1:0] r_exp_len, r_byte_cnt;
  logic [PKT_LEN_WIDTH-1:0] w_beat_bytes, w_byte_sum;
  logic                     r_len_err;

  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_beat_bytes = w_beat_bytes + PKT_LEN_WIDTH'(w_tkeep[i]);
    end
  end

  assign w_byte_sum = r_byte_cnt + w_beat_bytes;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_exp_len  <= '0;
      r_byte_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_exp_len <= fifo_packet_length[int'(w_cur_nxt)*PKT_LEN_WIDTH
                                        +: PKT_LEN_WIDTH];
      end
      if (w_take) r_byte_cnt <= w_last ? '0 : w_byte_sum;
      r_len_err <= w_last && (w_byte_sum != r_exp_len);
    end
  end

  assign len_err = r_len_err;
`else
  logic w_unused_len;
  assign w_unused_len = ^fifo_packet_length;
  assign len_err      = 1'b0;
`endif

  assign s_axis_tready = (r_state == XFER && w_out_free) ? w_onehot : '0;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign pe_tlast      = r_pe;
  assign busy          = (r_state == XFER);
  assign grant_drop    = r_drop;

endmodule

// File: tb/tb_sched_egress_mux.sv
// Bench for sched_egress_mux: directed vectors, corner sequences and
// randomized traffic checked against a grant-queue reference model.
module tb_sched_egress_mux;

  localparam int NQ = 9;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 4;
  localparam int LW = 16;
`ifdef SCHED_EGRESS_MUX_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [SW-1:0]     sel_in;
  logic              en_in;
  logic [NQ*LW-1:0]  fifo_packet_length;
  logic [NQ*DW-1:0]  s_axis_tdata;
  logic [NQ*KW-1:0]  s_axis_tkeep;
  logic [NQ-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [NQ-1:0]     pe_tlast;
  logic              busy, grant_drop, len_err;

  sched_egress_mux dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .en_in(en_in),
    .fifo_packet_length(fifo_packet_length),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pe_tlast(pe_tlast), .busy(busy), .grant_drop(grant_drop),
    .len_err(len_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [SW-1:0] sel;
    logic          en;
    logic          drop;
    logic          bsy;
    logic [NQ-1:0] rdy;
  } gvec_t;

  beat_t      srcq [NQ][$];
  int         lenq [NQ][$];
  beat_t      expq [$];
  int         order [$];
  int         accum [NQ];
  logic       mv_mod;
  logic [NQ-1:0] exp_pe;
  logic       exp_drop, exp_len;
  int         n_chk = 0;
  int         n_fail = 0;
  int         pkt_ctr = 0;
  int         egress_cnt = 0;
  logic       gaps = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NQ-1:0] oh(input int q);
    logic [NQ-1:0] v;
    v = '0;
    v[q] = 1'b1;
    return v;
  endfunction

  task automatic add_pkt(input int q, input int nb, input logic [7:0] lk,
                         input int decl);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = {8'(q), 8'(pkt_ctr), 8'(i), 8'h5a, $urandom};
      b.keep = (i == nb-1) ? lk : 8'hFF;
      b.last = (i == nb-1);
      srcq[q].push_back(b);
    end
    lenq[q].push_back(decl);
    pkt_ctr++;
  endtask

  task automatic add_rand(input int q);
    int nb;
    logic [7:0] lk;
    nb = $urandom_range(4, 1);
    lk = 8'($urandom_range(255, 1));
    add_pkt(q, nb, lk, 8*(nb-1) + $countones(lk)
            + (($urandom_range(7, 0) == 0) ? 1 : 0));
  endtask

  task automatic drive_src();
    for (int q = 0; q < NQ; q++) begin
      if (srcq[q].size() > 0) begin
        s_axis_tdata[q*DW +: DW] = srcq[q][0].data;
        s_axis_tkeep[q*KW +: KW] = srcq[q][0].keep;
        s_axis_tlast[q]  = srcq[q][0].last;
        s_axis_tvalid[q] = !gaps || ($urandom_range(2, 0) != 0);
      end else begin
        s_axis_tvalid[q] = 1'b0;
        s_axis_tlast[q]  = 1'b0;
      end
      fifo_packet_length[q*LW +: LW] =
        (lenq[q].size() > 0) ? LW'(lenq[q][0]) : '0;
    end
  endtask

  // One clock: drive at entry, sample/model at posedge, check at negedge.
  task automatic tick();
    int hq;
    beat_t b, e;
    logic [NQ-1:0] exp_rdy;
    drive_src();
    @(posedge clk);
    exp_pe = '0;
    exp_drop = 1'b0;
    exp_len = 1'b0;
    if (!rst) begin
      order.delete();
      expq.delete();
      for (int q = 0; q < NQ; q++) accum[q] = 0;
      mv_mod = 1'b0;
    end else begin
      exp_rdy = '0;
      if (order.size() > 0 && (!mv_mod || m_axis_tready))
        exp_rdy = oh(order[0]);
      chk("s_tready", s_axis_tready, exp_rdy);
      chk("m_tvalid", m_axis_tvalid, mv_mod);
      if (m_axis_tvalid && m_axis_tready) begin
        egress_cnt++;
        if (expq.size() == 0) begin
          chk("egress_extra_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("m_tdata", m_axis_tdata, e.data);
          chk("m_tkeep", m_axis_tkeep, e.keep);
          chk("m_tlast", m_axis_tlast, e.last);
        end
      end
      hq = -1;
      for (int q = 0; q < NQ; q++)
        if (s_axis_tvalid[q] && s_axis_tready[q]) hq = q;
      if (hq >= 0) begin
        b = srcq[hq].pop_front();
        expq.push_back(b);
        accum[hq] += $countones(b.keep);
        if (b.last) begin
          exp_pe = oh(hq);
          if (LEN_EN) exp_len = (accum[hq] != lenq[hq][0]);
          void'(lenq[hq].pop_front());
          accum[hq] = 0;
          if (order.size() > 0) void'(order.pop_front());
        end
        mv_mod = 1'b1;
      end else if (m_axis_tready) begin
        mv_mod = 1'b0;
      end
      if (en_in) begin
        if (sel_in < NQ && order.size() < 2) order.push_back(int'(sel_in));
        else exp_drop = 1'b1;
      end
    end
    @(negedge clk);
    chk("pe_tlast", pe_tlast, exp_pe);
    chk("grant_drop", grant_drop, exp_drop);
    chk("len_err", len_err, exp_len);
    chk("busy", busy, order.size() > 0);
    if (!rst) begin
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_m_tkeep", m_axis_tkeep, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
    end
  endtask

  task automatic drain();
    en_in = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 200 && (order.size() > 0 || mv_mod); c++) tick();
    chk("drain_done", order.size() > 0 || mv_mod, 0);
  endtask

  task automatic grant(input int q);
    sel_in = SW'(q);
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
  endtask

  initial begin
    gvec_t gt [5];
    logic [15:0] vm, pm, pm2, dm;
    int cnt, base;
    logic [DW-1:0] prev_d;
    logic stall;
    logic rdy_pat [15];
    int q;
    logic inord;

    gt[0] = '{sel: 4'd12, en: 1'b1, drop: 1'b1, bsy: 1'b0, rdy: 9'h000};
    gt[1] = '{sel: 4'd9,  en: 1'b1, drop: 1'b1, bsy: 1'b0, rdy: 9'h000};
    gt[2] = '{sel: 4'd15, en: 1'b1, drop: 1'b1, bsy: 1'b0, rdy: 9'h000};
    gt[3] = '{sel: 4'd2,  en: 1'b0, drop: 1'b0, bsy: 1'b0, rdy: 9'h000};
    gt[4] = '{sel: 4'd8,  en: 1'b1, drop: 1'b0, bsy: 1'b1, rdy: 9'h100};
    rdy_pat = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    rst = 1'b0;
    sel_in = '0;
    en_in = 1'b0;
    m_axis_tready = 1'b1;
    fifo_packet_length = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    mv_mod = 1'b0;
    for (int i = 0; i < NQ; i++) accum[i] = 0;
    repeat (3) tick();
    rst = 1'b1;

    // single 4-beat packet from queue 2
    add_pkt(2, 4, 8'hFF, 32);
    tick();
    grant(2);
    vm = '0; pm = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vm[k] = m_axis_tvalid;
      pm[k] = (pe_tlast == 9'h004);
    end
    chk("t1_valid_mask", vm, 16'h000F);
    chk("t1_pe_mask", pm, 16'h0008);
    drain();

    // back-to-back grants 1 then 4
    add_pkt(1, 3, 8'hFF, 24);
    add_pkt(4, 3, 8'hFF, 24);
    tick();
    grant(1);
    vm = '0; pm = '0; pm2 = '0;
    for (int k = 0; k < 10; k++) begin
      en_in = (k == 0);
      sel_in = 4'd4;
      tick();
      vm[k]  = m_axis_tvalid;
      pm[k]  = (pe_tlast == oh(1));
      pm2[k] = (pe_tlast == oh(4));
    end
    en_in = 1'b0;
    chk("t2_valid_mask", vm, 16'h003F);
    chk("t2_pe1_mask", pm, 16'h0004);
    chk("t2_pe4_mask", pm2, 16'h0020);
    drain();

    // overflow: third grant while one is pending
    add_pkt(0, 4, 8'hFF, 32);
    add_pkt(3, 2, 8'hFF, 16);
    add_pkt(5, 2, 8'hFF, 16);
    tick();
    grant(0);
    dm = '0; pm = '0; pm2 = '0; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      en_in = (k < 2);
      sel_in = (k == 0) ? 4'd3 : 4'd5;
      tick();
      dm[k]  = grant_drop;
      pm[k]  = (pe_tlast == oh(0));
      pm2[k] = (pe_tlast == oh(3));
      if (pe_tlast[5]) cnt++;
    end
    en_in = 1'b0;
    chk("t3_drop_mask", dm, 16'h0002);
    chk("t3_pe0_mask", pm, 16'h0008);
    chk("t3_pe3_mask", pm2, 16'h0020);
    chk("t3_pe5_count", cnt, 0);
    chk("t3_q5_untouched", srcq[5].size(), 2);
    drain();

    // egress backpressure during a 5-beat packet
    add_pkt(6, 5, 8'hFF, 40);
    tick();
    grant(6);
    base = egress_cnt;
    for (int k = 0; k < 15; k++) begin
      prev_d = m_axis_tdata;
      m_axis_tready = rdy_pat[k];
      stall = m_axis_tvalid && !m_axis_tready;
      tick();
      if (stall) begin
        chk("t4_hold_data", m_axis_tdata, prev_d);
        chk("t4_hold_valid", m_axis_tvalid, 1);
      end
    end
    chk("t4_beat_count", egress_cnt - base, 5);
    drain();

    // grant validity table from IDLE
    add_pkt(8, 1, 8'h0F, 4);
    tick();
    for (int i = 0; i < 5; i++) begin
      sel_in = gt[i].sel;
      en_in = gt[i].en;
      tick();
      en_in = 1'b0;
      chk("t5_drop", grant_drop, gt[i].drop);
      chk("t5_busy", busy, gt[i].bsy);
      chk("t5_ready", s_axis_tready, gt[i].rdy);
    end
    drain();

    // length check: matching then short packet
    add_pkt(7, 3, 8'h0F, 20);
    tick();
    grant(7);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (len_err) cnt++;
    end
    chk("t6_len_ok", cnt, 0);
    add_pkt(7, 3, 8'h03, 20);
    tick();
    grant(7);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (len_err) cnt++;
    end
    chk("t6_len_short", cnt, LEN_EN ? 1 : 0);
    drain();

    // reset in the middle of a packet
    add_pkt(3, 6, 8'hFF, 48);
    tick();
    grant(3);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    srcq[3].delete();
    lenq[3].delete();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (pe_tlast != '0) cnt++;
    end
    chk("t7_no_pe", cnt, 0);
    chk("t7_idle", busy, 0);

    // randomized traffic
    gaps = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      m_axis_tready = ($urandom_range(3, 0) != 0);
      en_in = 1'b0;
      if ($urandom_range(2, 0) == 0) begin
        if ($urandom_range(9, 0) == 0) begin
          sel_in = SW'($urandom_range(15, 9));
          en_in = 1'b1;
        end else begin
          q = int'($urandom_range(NQ-1, 0));
          inord = 1'b0;
          foreach (order[j]) if (order[j] == q) inord = 1'b1;
          if (!inord) begin
            if (srcq[q].size() == 0) add_rand(q);
            sel_in = SW'(q);
            en_in = 1'b1;
          end
        end
      end
      tick();
    end
    gaps = 1'b0;
    drain();
    chk("end_expq_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
